// File: rtl/test_sequencer.sv
// Scan-style test sequencer: a 24-bit serial configuration register is
// committed to a select word and a run length. A capture run then samples
// the observed test bus for runLen cycles and produces a signature.
// Optional feature: define TEST_SEQ_MISR_EN to compact samples into a
// 16-bit MISR; otherwise the signature is the last sample taken.
module test_sequencer (
    input  logic        inClock,
    input  logic        inReset,
    input  logic        inShiftEn,
    input  logic        inShiftData,
    input  logic        inUpdate,
    input  logic        inStart,
    input  logic [3:0]  inObserve,
    output logic        outShiftData,
    output logic [15:0] outSel,
    output logic        outBusy,
    output logic        outDone,
    output logic [15:0] outSignature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] sr_q, sr_d;
    logic [15:0] sel_q, sel_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] sig_q, sig_d;
    logic [7:0]  cnt_inc;

`ifdef TEST_SEQ_MISR_EN
    // One MISR step: shift left, fold in the feedback taps, then XOR the sample.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [3:0]  obs);
        logic [15:0] shifted;
        shifted = {sig[14:0], 1'b0} ^ (sig[15] ? 16'hA011 : 16'h0000);
        return shifted ^ {12'h000, obs};
    endfunction
`endif

    // 8-bit increment wraps to zero, so runLen = 0 naturally means 256 cycles.
    assign cnt_inc = cnt_q + 8'd1;

    // Next-state logic: shift register runs in every state, commit/start only in IDLE.
    always_comb begin
        state_d = state_q;
        sr_d    = inShiftEn ? {sr_q[22:0], inShiftData} : sr_q;
        sel_d   = sel_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        case (state_q)
            IDLE: begin
                // Commit uses the pre-shift contents, so a same-cycle shift is not seen.
                if (inUpdate) begin
                    sel_d = sr_q[15:0];
                    len_d = sr_q[23:16];
                end
                if (inStart) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                    sig_d   = 16'h0000;
                end
            end
            RUN: begin
`ifdef TEST_SEQ_MISR_EN
                sig_d = misr_step(sig_q, inObserve);
`else
                sig_d = {12'h000, inObserve};
`endif
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            state_q <= IDLE;
            sr_q    <= 24'h000000;
            sel_q   <= 16'h0000;
            len_q   <= 8'd0;
            cnt_q   <= 8'd0;
            sig_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    assign outShiftData = sr_q[23];
    assign outSel       = sel_q;
    assign outBusy      = (state_q == RUN);
    assign outDone      = (state_q == DONE);
    assign outSignature = sig_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer. A timeline model tracks each run as a start
// edge plus a length and derives busy/done/signature expectations from it.
module tb_test_sequencer;

    logic        clk;
    logic        rst;
    logic        shen;
    logic        sd;
    logic        upd;
    logic        start;
    logic [3:0]  obs;
    logic        outShiftData;
    logic [15:0] outSel;
    logic        outBusy;
    logic        outDone;
    logic [15:0] outSignature;

    int checks = 0;
    int errors = 0;

    test_sequencer dut (
        .inClock      (clk),
        .inReset      (rst),
        .inShiftEn    (shen),
        .inShiftData  (sd),
        .inUpdate     (upd),
        .inStart      (start),
        .inObserve    (obs),
        .outShiftData (outShiftData),
        .outSel       (outSel),
        .outBusy      (outBusy),
        .outDone      (outDone),
        .outSignature (outSignature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sig_step(input logic [15:0] sig, input logic [3:0] o);
`ifdef TEST_SEQ_MISR_EN
        logic [15:0] t;
        t = {sig[14:0], 1'b0};
        if (sig[15]) t = t ^ 16'hA011;
        return t ^ {12'h000, o};
`else
        if (sig == 16'hFFFF) return {12'h000, o};
        return {12'h000, o};
`endif
    endfunction

    // ---------------- timeline model ----------------
    int          e = 0;          // number of rising edges seen
    int          s = 0;          // edge at which the current run was started
    int          L = 0;          // length of the current run in cycles
    bit          run_valid = 0;
    logic [23:0] m_sr  = '0;
    logic [15:0] m_sel = '0;
    logic [7:0]  m_len = '0;
    logic [15:0] m_sig = '0;
    bit          mon_en = 0;

    // Period p is the interval after edge p: busy for p in [s, s+L-1], done at s+L.
    always @(posedge clk) begin
        bit idle_before;
        e++;
        idle_before = !(run_valid && (e - 1) >= s && (e - 1) <= s + L);
        if (!rst) begin
            m_sr = '0; m_sel = '0; m_len = '0; m_sig = '0;
            run_valid = 0;
        end else begin
            if (run_valid && e >= s + 1 && e <= s + L) m_sig = sig_step(m_sig, obs);
            if (idle_before && upd) begin
                m_sel = m_sr[15:0];
                m_len = m_sr[23:16];
            end
            if (idle_before && start) begin
                s = e;
                L = (m_len == 8'd0) ? 256 : int'(m_len);
                run_valid = 1;
                m_sig = '0;
            end
            if (shen) m_sr = {m_sr[22:0], sd};
        end
    end

    // Compare every cycle against the model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("shiftdata", {31'd0, outShiftData}, {31'd0, m_sr[23]});
            chk("sel", {16'd0, outSel}, {16'd0, m_sel});
            chk("busy", {31'd0, outBusy}, {31'd0, run_valid && e >= s && e <= s + L - 1});
            chk("done", {31'd0, outDone}, {31'd0, run_valid && e == s + L});
            chk("signature", {16'd0, outSignature}, {16'd0, m_sig});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift24(input logic [23:0] v);
        for (int i = 23; i >= 0; i--) begin
            shen = 1'b1;
            sd   = v[i];
            tick();
        end
        shen = 1'b0;
    endtask

    task automatic commit();
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    // Count busy periods until the done pulse, bounded.
    task automatic wait_done(output int nb, output bit ok);
        nb = 0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (outBusy) nb++;
            if (outDone) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        bit ok;
        int dn;
        rst = 1'b0; shen = 1'b0; sd = 1'b0; upd = 1'b0; start = 1'b0; obs = 4'h0;
        tick();
        mon_en = 1;
        tick();
        @(negedge clk);
        chk("reset_sel", {16'd0, outSel}, 32'h0);
        chk("reset_busy", {31'd0, outBusy}, 32'h0);
        chk("reset_done", {31'd0, outDone}, 32'h0);
        chk("reset_sig", {16'd0, outSignature}, 32'h0);
        chk("reset_sdo", {31'd0, outShiftData}, 32'h0);
        rst = 1'b1;

        // Configuration load
        shift24(24'h041234);
        commit();
        @(negedge clk);
        chk("commit_sel", {16'd0, outSel}, 32'h1234);

        // runLen = 4, all-zero observation
        obs = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nb, ok);
        chk("run4_done_seen", {31'd0, ok}, 32'd1);
        chk("run4_busy_cycles", nb, 32'd4);
        chk("run4_sig", {16'd0, outSignature}, 32'h0000);

`ifdef TEST_SEQ_MISR_EN
        shift24(24'h020000);
        commit();
        obs = 4'h1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nb, ok);
        chk("misr_sig", {16'd0, outSignature}, 32'h0003);
`else
        shift24(24'h030000);
        commit();
        start = 1'b1;
        tick();
        start = 1'b0;
        obs = 4'h5;
        tick();
        obs = 4'h7;
        tick();
        obs = 4'hA;
        wait_done(nb, ok);
        chk("last_sample_sig", {16'd0, outSignature}, 32'h000A);
`endif
        chk("sig_run_done", {31'd0, ok}, 32'd1);

        // runLen = 0 means 256 cycles
        shift24(24'h00ABCD);
        commit();
        obs = 4'h6;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nb, ok);
        chk("run256_done_seen", {31'd0, ok}, 32'd1);
        chk("run256_busy_cycles", nb, 32'd256);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            if (outDone) dn++;
        end
        chk("run256_single_done", dn, 32'd0);

        // Reset during RUN cycle 2
        shift24(24'h051111);
        commit();
        obs = 4'h3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_busy", {31'd0, outBusy}, 32'h0);
        chk("abort_sel", {16'd0, outSel}, 32'h0);
        chk("abort_sig", {16'd0, outSignature}, 32'h0);
        rst = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (outDone) dn++;
        end
        chk("abort_no_done", dn, 32'd0);

        // Update and start together; update and shift during RUN
        shift24(24'h0200FF);
        upd = 1'b1;
        start = 1'b1;
        tick();
        upd = 1'b0;
        start = 1'b0;
        upd = 1'b1;
        shen = 1'b1;
        sd = 1'b1;
        wait_done(nb, ok);
        upd = 1'b0;
        shen = 1'b0;
        chk("combo_done_seen", {31'd0, ok}, 32'd1);
        chk("combo_busy_cycles", nb, 32'd2);
        chk("combo_sel_held", {16'd0, outSel}, 32'h00FF);
        upd = 1'b1;
        tick();
        tick();
        upd = 1'b0;
        @(negedge clk);
        chk("post_run_commit", {16'd0, outSel}, 32'h03FF);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
